fp_comm_scoreboard: RTL

- Clocked commutativity scoreboard for pipelined FP adders.
- Accepts two in-order result streams: channel A carries op(a,b), channel B carries op(b,a). The two streams may have different latency and jitter.
- Buffers each stream, compares result word and overflow/underflow flags pairwise, counts pairs and mismatches, detects overflow and starvation.
- Successor to the combinational commutativity harness: parametrised format, with buffering, state and error reporting for multi-cycle DUTs.

---
 rtl/fp_comm_scoreboard.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fp_comm_scoreboard.sv
// Commutativity scoreboard: buffers op(a,b) / op(b,a) result streams and compares them pairwise.
// Optional FP_COMM_NAN_EQ_EN: any two NaN words compare equal (flags still compared).
module fp_comm_scoreboard #(
   parameter int EXP_W       = 8,
   parameter int MAN_W       = 23,
   parameter int DEPTH       = 4,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 64,
   parameter int STOP_ON_ERR = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   clr,
   input  logic                   a_valid,
   input  logic [EXP_W+MAN_W:0]   a_result,
   input  logic [1:0]             a_flags,
   input  logic                   b_valid,
   input  logic [EXP_W+MAN_W:0]   b_result,
   input  logic [1:0]             b_flags,
   output logic                   mismatch,
   output logic                   err_sticky,
   output logic                   ovf_sticky,
   output logic                   tmo_sticky,
   output logic [CNT_W-1:0]       pair_count,
   output logic [CNT_W-1:0]       mis_count,
   output logic [CNT_W-1:0]       first_mis_idx,
   output logic [1:0]             state
);
   // state  | meaning
   // IDLE   | waiting for en, inputs ignored
   // RUN    | pushing, popping and comparing
   // HALT   | frozen after mismatch (STOP_ON_ERR), overflow or timeout; only clr/reset exits

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int E  = W + 2;
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10} state_t;
   state_t state_q, state_d;

   logic [E-1:0]  mem_a [DEPTH];
   logic [E-1:0]  mem_b [DEPTH];
   logic [AW:0]   wr_a, rd_a, wr_b, rd_b;
   logic [TW-1:0] tmo_cnt;
   logic [E-1:0]  head_a, head_b;
   logic          empty_a, empty_b, full_a, full_b;
   logic          run, pop, push_a, push_b, drop_a, drop_b;
   logic          tmo_inc, tmo_hit, pair_eq, mis_evt;

   function automatic logic words_eq(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef FP_COMM_NAN_EQ_EN
      logic x_nan, y_nan;
      x_nan = (&x[W-2 -: EXP_W]) && (|x[MAN_W-1:0]);
      y_nan = (&y[W-2 -: EXP_W]) && (|y[MAN_W-1:0]);
      return (x == y) || (x_nan && y_nan);
`else
      return x == y;
`endif
   endfunction

   assign empty_a = (wr_a == rd_a);
   assign empty_b = (wr_b == rd_b);
   assign full_a  = (wr_a[AW] != rd_a[AW]) && (wr_a[AW-1:0] == rd_a[AW-1:0]);
   assign full_b  = (wr_b[AW] != rd_b[AW]) && (wr_b[AW-1:0] == rd_b[AW-1:0]);
   assign head_a  = mem_a[rd_a[AW-1:0]];
   assign head_b  = mem_b[rd_b[AW-1:0]];
   assign state   = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (en) state_d = S_RUN;
            S_RUN:  if (drop_a || drop_b || tmo_hit || (mis_evt && STOP_ON_ERR != 0))
                       state_d = S_HALT;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A full FIFO still accepts a push when its head is leaving in the same cycle.
   always_comb begin
      run     = (state_q == S_RUN) && !clr;
      pop     = run && !empty_a && !empty_b;
      push_a  = run && a_valid && (!full_a || pop);
      push_b  = run && b_valid && (!full_b || pop);
      drop_a  = run && a_valid && full_a && !pop;
      drop_b  = run && b_valid && full_b && !pop;
      tmo_inc = run && (empty_a ^ empty_b) && !pop;
      tmo_hit = tmo_inc && (tmo_cnt == TW'(TIMEOUT - 1));
      pair_eq = words_eq(head_a[E-1:2], head_b[E-1:2]) && (head_a[1:0] == head_b[1:0]);
      mis_evt = pop && !pair_eq;
   end

   always_ff @(posedge clk) begin
      if (push_a) mem_a[wr_a[AW-1:0]] <= {a_result, a_flags};
      if (push_b) mem_b[wr_b[AW-1:0]] <= {b_result, b_flags};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_a          <= '0;
         rd_a          <= '0;
         wr_b          <= '0;
         rd_b          <= '0;
         tmo_cnt       <= '0;
         mismatch      <= 1'b0;
         err_sticky    <= 1'b0;
         ovf_sticky    <= 1'b0;
         tmo_sticky    <= 1'b0;
         pair_count    <= '0;
         mis_count     <= '0;
         first_mis_idx <= '0;
      end else if (clr) begin
         wr_a          <= '0;
         rd_a          <= '0;
         wr_b          <= '0;
         rd_b          <= '0;
         tmo_cnt       <= '0;
         mismatch      <= 1'b0;
         err_sticky    <= 1'b0;
         ovf_sticky    <= 1'b0;
         tmo_sticky    <= 1'b0;
         pair_count    <= '0;
         mis_count     <= '0;
         first_mis_idx <= '0;
      end else begin
         mismatch <= mis_evt;
         if (push_a) wr_a <= wr_a + (AW+1)'(1);
         if (push_b) wr_b <= wr_b + (AW+1)'(1);
         if (pop) begin
            rd_a <= rd_a + (AW+1)'(1);
            rd_b <= rd_b + (AW+1)'(1);
            if (pair_count != '1) pair_count <= pair_count + CNT_W'(1);
         end
         if (mis_evt) begin
            err_sticky <= 1'b1;
            if (mis_count != '1) mis_count <= mis_count + CNT_W'(1);
            if (!err_sticky) first_mis_idx <= pair_count;
         end
         if (drop_a || drop_b) ovf_sticky <= 1'b1;
         if (tmo_hit) tmo_sticky <= 1'b1;
         if (run) begin
            if (pop || (empty_a && empty_b)) tmo_cnt <= '0;
            else if (tmo_inc)                tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end

endmodule
